// File: rtl/irq_sched_pkg.sv
// Shared types and limits for the interrupt scheduler.
package irq_sched_pkg;

   localparam int unsigned MAX_SRC = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      HOLDOFF = 2'd2
   } irq_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping to 0.
module rr_arbiter #(
   parameter int unsigned N    = 8,
   parameter int unsigned ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [ID_W:0]  pos;
   logic [ID_W:0]  wrap;

   assign dbl = {req, req};

   // Scanning the doubled vector from ptr gives the wrap-around order without a modulo.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      pos  = '0;
      wrap = '0;
      for (int k = 0; k < int'(N); k++) begin
         pos = {1'b0, ptr} + (ID_W+1)'(k);
         if (!any && dbl[pos]) begin
            any  = 1'b1;
            wrap = (pos >= (ID_W+1)'(N)) ? pos - (ID_W+1)'(N) : pos;
            idx  = ID_W'(wrap);
         end
      end
   end

endmodule

// File: rtl/irq_scheduler.sv
// Latches event pulses as pending bits and grants one unmasked source at a time
// to the CPU with a valid/ack handshake and a programmable post-ack holdoff.
module irq_scheduler
   import irq_sched_pkg::*;
#(
   parameter int unsigned N_SRC  = 8,
   parameter int unsigned ID_W   = $clog2(N_SRC),
   parameter int unsigned HOLD_W = 16
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              enable_i,
   input  logic [N_SRC-1:0]  mask_i,
   input  logic [HOLD_W-1:0] holdoff_i,
   input  logic              clear_all_i,
   input  logic [N_SRC-1:0]  event_i,
   output logic              irq_o,
   output logic [ID_W-1:0]   irq_id_o,
   input  logic              ack_i,
   output logic [N_SRC-1:0]  pending_o,
   output logic [N_SRC-1:0]  overflow_o
);

   irq_sched_state_t  state, state_nxt;
   logic [HOLD_W-1:0] cnt, cnt_nxt;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   arb_idx;
   logic              arb_any;
   logic              grant_load;
   logic              ack_take;
   logic [N_SRC-1:0]  cand;
   logic [N_SRC-1:0]  clr;
   logic [N_SRC-1:0]  pend_nxt;
   logic [N_SRC-1:0]  ovf_nxt;

   // Only registered pending bits compete; a same-cycle event waits one cycle.
   assign cand = pending_o & mask_i;

   rr_arbiter #(
      .N    (N_SRC),
      .ID_W (ID_W)
   ) u_arb (
      .req (cand),
      .ptr (ptr),
      .any (arb_any),
      .idx (arb_idx)
   );

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      grant_load = 1'b0;
      ack_take   = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i && arb_any) begin
               state_nxt  = GRANT;
               grant_load = 1'b1;
            end
         end
         GRANT: begin
            if (ack_i) begin
               ack_take = 1'b1;
               if (holdoff_i == '0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = HOLDOFF;
                  cnt_nxt   = holdoff_i;
               end
            end
         end
         HOLDOFF: begin
            if (cnt <= HOLD_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - HOLD_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Set wins over clear, so an event coincident with its own clear stays pending.
   always_comb begin
      clr = '0;
      if (ack_take) begin
         clr = N_SRC'(1) << irq_id_o;
      end
      if (clear_all_i) begin
         clr = '1;
      end
      pend_nxt = (pending_o & ~clr) | event_i;
      ovf_nxt  = clear_all_i ? '0 : (overflow_o | (event_i & pending_o & ~clr));
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ptr        <= '0;
         irq_o      <= 1'b0;
         irq_id_o   <= '0;
         pending_o  <= '0;
         overflow_o <= '0;
      end else begin
         irq_o      <= (state_nxt == GRANT);
         pending_o  <= pend_nxt;
         overflow_o <= ovf_nxt;
         if (grant_load) begin
            irq_id_o <= arb_idx;
         end
         if (ack_take) begin
            ptr <= (irq_id_o == ID_W'(N_SRC - 1)) ? '0 : irq_id_o + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_irq_scheduler.sv
// Randomized bench for irq_scheduler: a cycle-level reference model predicts grants,
// pending and overflow; a monitor pops expected ids when irq_o rises.
module tb_irq_scheduler;

   localparam int N      = 8;
   localparam int ID_W   = 3;
   localparam int HOLD_W = 16;

   logic              clk;
   logic              arst_n_i;
   logic              enable_i;
   logic [N-1:0]      mask_i;
   logic [HOLD_W-1:0] holdoff_i;
   logic              clear_all_i;
   logic [N-1:0]      event_i;
   logic              irq_o;
   logic [ID_W-1:0]   irq_id_o;
   logic              ack_i;
   logic [N-1:0]      pending_o;
   logic [N-1:0]      overflow_o;

   int checks = 0;
   int errors = 0;

   irq_scheduler #(.N_SRC(N), .ID_W(ID_W), .HOLD_W(HOLD_W)) dut (
      .clk_i       (clk),
      .arst_n_i    (arst_n_i),
      .enable_i    (enable_i),
      .mask_i      (mask_i),
      .holdoff_i   (holdoff_i),
      .clear_all_i (clear_all_i),
      .event_i     (event_i),
      .irq_o       (irq_o),
      .irq_id_o    (irq_id_o),
      .ack_i       (ack_i),
      .pending_o   (pending_o),
      .overflow_o  (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: pending set, outstanding grant, rr pointer and the earliest
   // cycle at which a new grant may be issued.
   logic [N-1:0] mpend, movf, mclr;
   bit  mgranted, ack_eff, found;
   int  mid, mptr, cyc, earliest, win, cand_n;
   int  exp_q[$];

   always @(posedge clk or negedge arst_n_i) begin
      if (!arst_n_i) begin
         mpend = '0; movf = '0; mgranted = 0; mid = 0; mptr = 0;
         cyc = 0; earliest = 0;
         exp_q.delete();
      end else begin
         cyc++;
         ack_eff = mgranted && ack_i;
         mclr = clear_all_i ? '1 : '0;
         if (ack_eff) mclr[mid] = 1'b1;
         if (!mgranted && cyc >= earliest && enable_i) begin
            found = 0;
            win = 0;
            for (int k = 0; k < N; k++) begin
               cand_n = (mptr + k) % N;
               if (!found && mpend[cand_n] && mask_i[cand_n]) begin
                  found = 1;
                  win = cand_n;
               end
            end
            if (found) begin
               mgranted = 1;
               mid = win;
               exp_q.push_back(win);
            end
         end else if (ack_eff) begin
            mgranted = 0;
            mptr = (mid + 1) % N;
            earliest = cyc + int'(holdoff_i) + 1;
         end
         for (int n = 0; n < N; n++) begin
            movf[n]  = clear_all_i ? 1'b0 : (movf[n] | (event_i[n] & mpend[n] & ~mclr[n]));
            mpend[n] = (mpend[n] & ~mclr[n]) | event_i[n];
         end
      end
   end

   // Monitor: compares DUT outputs against the model away from the active edge.
   bit irq_q;
   int e;
   always @(negedge clk) begin
      if (!arst_n_i) begin
         irq_q = 0;
      end else begin
         chk("irq", 32'(irq_o), 32'(mgranted));
         if (irq_o && !irq_q) begin
            if (exp_q.size() == 0) begin
               chk("grant_expected", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("grant_id", 32'(irq_id_o), 32'(e));
            end
         end else if (irq_o) begin
            chk("id_hold", 32'(irq_id_o), 32'(mid));
         end
         chk("pending", 32'(pending_o), 32'(mpend));
         chk("overflow", 32'(overflow_o), 32'(movf));
         irq_q = irq_o;
      end
   end

   task automatic drive_idle();
      enable_i = 1'b1; mask_i = '1; holdoff_i = '0;
      clear_all_i = 1'b0; event_i = '0; ack_i = 1'b0;
   endtask

   task automatic run_phase(input int cycles, input int hold_max, input bit rand_mask);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         event_i     = N'($urandom & $urandom & $urandom);
         mask_i      = rand_mask ? N'($urandom) : '1;
         enable_i    = ($urandom % 8) != 0;
         clear_all_i = ($urandom % 40) == 0;
         holdoff_i   = HOLD_W'($urandom_range(0, hold_max));
         ack_i       = irq_o ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      end
   endtask

   task automatic mid_grant_reset();
      int n = 0;
      while (!irq_o && n < 200) begin
         @(negedge clk);
         event_i = N'($urandom);
         mask_i = '1; enable_i = 1'b1; ack_i = 1'b0; clear_all_i = 1'b0;
         n++;
      end
      chk("reach_grant", 32'(irq_o), 32'(1));
      @(negedge clk);
      event_i = N'(8'h30);
      #2 arst_n_i = 1'b0;
      #1;
      chk("arst_irq", 32'(irq_o), 32'(0));
      chk("arst_id", 32'(irq_id_o), 32'(0));
      chk("arst_pending", 32'(pending_o), 32'(0));
      chk("arst_overflow", 32'(overflow_o), 32'(0));
      drive_idle();
      repeat (2) @(negedge clk);
      #2 arst_n_i = 1'b1;
   endtask

   initial begin
      drive_idle();
      arst_n_i = 1'b0;
      repeat (3) @(negedge clk);
      #2 arst_n_i = 1'b1;
      @(negedge clk);
      chk("rst_irq", 32'(irq_o), 32'(0));
      chk("rst_id", 32'(irq_id_o), 32'(0));
      chk("rst_pending", 32'(pending_o), 32'(0));
      chk("rst_overflow", 32'(overflow_o), 32'(0));

      run_phase(300, 0, 1'b0);
      run_phase(400, 0, 1'b1);
      run_phase(600, 6, 1'b1);
      mid_grant_reset();
      run_phase(400, 3, 1'b0);

      // Drain: ack everything until no source remains pending.
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         drive_idle();
         ack_i = irq_o;
      end
      @(negedge clk);
      chk("drain_pending", 32'(pending_o), 32'(0));
      chk("drain_queue", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
